nios2_oci_dct_packer: RTL

Direct-branch trace (DCT) packer for the Nios II on-chip instrumentation (OCI) trace path. It accumulates 2-bit retirement codes from the CPU trace port into a 30-bit shift buffer and exposes the live buffer and fill count (`dct_buffer`, `dct_count`) to the OCI test-bench stage. It emits completed buffers as frames over a valid/ready handshake to the trace FIFO.

---
 rtl/nios2_oci_dct_packer.sv | 106 ++++++++++
 1 files changed

// File: rtl/nios2_oci_dct_packer.sv
// nios2_oci_dct_packer: packs 2-bit direct-branch retirement codes into
// 30-bit frames and hands them to the trace FIFO over valid/ready.
// Optional feature macro: DCT_DROP_CNT_EN adds a saturating 8-bit
// dct_drop_count output; without it dct_overflow is a single sticky bit.
module nios2_oci_dct_packer #(
  parameter int DCT_DEPTH = 15,
  localparam int BW = 2 * DCT_DEPTH,
  localparam int CW = $clog2(DCT_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trc_on,
  input  logic             dct_valid,
  input  logic [1:0]       dct_code,
  input  logic             flush,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [BW+CW+1:0] frame_data,
  output logic [BW-1:0]    dct_buffer,
  output logic [CW-1:0]    dct_count,
`ifdef DCT_DROP_CNT_EN
  output logic [7:0]       dct_drop_count,
`endif
  output logic             dct_overflow
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DCT_DEPTH);

  logic trc_on_d;
  logic flush_pend;
  logic accept;
  logic out_free;
  logic is_full;
  logic is_empty;
  logic emit;
  logic drop;
  logic trc_fall;

  // Decode this cycle's accept / emit / drop decisions from live state.
  always_comb begin
    accept   = trc_on && dct_valid;
    out_free = !frame_valid || frame_ready;
    is_full  = (dct_count == FULL_COUNT);
    is_empty = (dct_count == '0);
    emit     = (is_full || flush_pend) && !is_empty && out_free;
    drop     = accept && is_full && !emit;
    trc_fall = trc_on_d && !trc_on;
  end

  // Remember the previous trace enable so a falling edge can request a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trc_on_d <= 1'b0;
    else       trc_on_d <= trc_on;
  end

  // A new flush request always wins; otherwise an emit or an empty buffer retires it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              flush_pend <= 1'b0;
    else if (flush || trc_fall)             flush_pend <= 1'b1;
    else if (emit || (flush_pend && is_empty)) flush_pend <= 1'b0;
  end

  // Accumulation buffer: on emit a same-cycle code seeds the fresh buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (emit) begin
      dct_buffer <= accept ? {{(BW-2){1'b0}}, dct_code} : '0;
      dct_count  <= accept ? CW'(1) : '0;
    end else if (accept && !is_full) begin
      dct_buffer <= {dct_buffer[BW-3:0], dct_code};
      dct_count  <= dct_count + CW'(1);
    end
  end

  // Output frame register: loaded on emit, held under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_valid <= 1'b0;
      frame_data  <= '0;
    end else if (emit) begin
      frame_valid <= 1'b1;
      frame_data  <= {2'b10, dct_count, dct_buffer};
    end else if (frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

`ifdef DCT_DROP_CNT_EN
  // Count dropped codes, saturating so the counter never wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             dct_drop_count <= '0;
    else if (drop && dct_drop_count != 8'hFF) dct_drop_count <= dct_drop_count + 8'd1;
  end

  assign dct_overflow = (dct_drop_count != 8'd0);
`else
  // Sticky flag recording that at least one code was lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     dct_overflow <= 1'b0;
    else if (drop) dct_overflow <= 1'b1;
  end
`endif

endmodule
